// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline registers (ID/EX, EX/MEM, MEM/WB) behind the ID-stage decoder,
// with load-use / ID-branch hazard detection that produces the front-end Stall.
`timescale 1ns/1ps

module ctrl_pipe_hazard #(
    parameter int          CNT_W    = 16,
    parameter int unsigned LINK_REG = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       id_ex_ctrl,
    input  logic [5:0]       id_mem_ctrl,
    input  logic [9:0]       id_wb_ctrl,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             flush,
    output logic [8:0]       ex_ctrl,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_dst,
    output logic [5:0]       mem_ctrl,
    output logic [4:0]       mem_dst,
    output logic [9:0]       wb_ctrl,
    output logic [4:0]       wb_dst,
    output logic             Stall,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MEMREAD_BIT  = 0;
    localparam int REGWRITE_BIT = 0;

    // ID/EX register: the EX group plus the MEM/WB groups that ride along with it
    logic [8:0]       ex_ctrl_q, ex_ctrl_d;
    logic [5:0]       ex_mem_q, ex_mem_d;
    logic [9:0]       ex_wb_q, ex_wb_d;
    logic [4:0]       ex_rs_q, ex_rs_d;
    logic [4:0]       ex_rt_q, ex_rt_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [5:0]       mem_ctrl_q, mem_ctrl_d;
    logic [9:0]       mem_wb_q, mem_wb_d;
    logic [4:0]       mem_dst_q, mem_dst_d;
    logic [9:0]       wb_ctrl_q, wb_ctrl_d;
    logic [4:0]       wb_dst_q, wb_dst_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [4:0] ex_dst_c;
    logic       hz_load_use, hz_br_alu, hz_br_load, stall_c;

    function automatic logic id_reads(input logic [4:0] dst,
                                      input logic [4:0] rs, input logic use_rs,
                                      input logic [4:0] rt, input logic use_rt);
        return (dst != 5'd0) && (((dst == rs) && use_rs) || ((dst == rt) && use_rt));
    endfunction

    always_comb begin
        ex_dst_c = 5'd0;
        unique case (ex_ctrl_q[3:2])
            2'd0:    ex_dst_c = ex_rt_q;
            2'd1:    ex_dst_c = ex_rd_q;
            2'd2:    ex_dst_c = 5'(LINK_REG);
            default: ex_dst_c = 5'd0;
        endcase

        hz_load_use = ex_mem_q[MEMREAD_BIT] && ex_wb_q[REGWRITE_BIT] &&
                      id_reads(ex_dst_c, id_rs, id_uses_rs, id_rt, id_uses_rt);
        hz_br_alu   = id_is_branch && ex_wb_q[REGWRITE_BIT] &&
                      id_reads(ex_dst_c, id_rs, id_uses_rs, id_rt, id_uses_rt);
        hz_br_load  = id_is_branch && mem_ctrl_q[MEMREAD_BIT] && mem_wb_q[REGWRITE_BIT] &&
                      id_reads(mem_dst_q, id_rs, id_uses_rs, id_rt, id_uses_rt);
        stall_c     = hz_load_use || hz_br_alu || hz_br_load;
    end

    // Stalled or squashed instructions become an all-zero bubble; later stages always advance
    always_comb begin
        ex_ctrl_d = id_ex_ctrl;
        ex_mem_d  = id_mem_ctrl;
        ex_wb_d   = id_wb_ctrl;
        ex_rs_d   = id_rs;
        ex_rt_d   = id_rt;
        ex_rd_d   = id_rd;
        if (stall_c || flush) begin
            ex_ctrl_d = '0;
            ex_mem_d  = '0;
            ex_wb_d   = '0;
            ex_rs_d   = '0;
            ex_rt_d   = '0;
            ex_rd_d   = '0;
        end

        mem_ctrl_d = ex_mem_q;
        mem_wb_d   = ex_wb_q;
        mem_dst_d  = ex_dst_c;
        wb_ctrl_d  = mem_wb_q;
        wb_dst_d   = mem_dst_q;

        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q     <= '0;
            ex_mem_q      <= '0;
            ex_wb_q       <= '0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            mem_ctrl_q    <= '0;
            mem_wb_q      <= '0;
            mem_dst_q     <= '0;
            wb_ctrl_q     <= '0;
            wb_dst_q      <= '0;
            stall_count_q <= '0;
        end else begin
            ex_ctrl_q     <= ex_ctrl_d;
            ex_mem_q      <= ex_mem_d;
            ex_wb_q       <= ex_wb_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_rd_q       <= ex_rd_d;
            mem_ctrl_q    <= mem_ctrl_d;
            mem_wb_q      <= mem_wb_d;
            mem_dst_q     <= mem_dst_d;
            wb_ctrl_q     <= wb_ctrl_d;
            wb_dst_q      <= wb_dst_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_ctrl     = ex_ctrl_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_dst      = ex_dst_c;
    assign mem_ctrl    = mem_ctrl_q;
    assign mem_dst     = mem_dst_q;
    assign wb_ctrl     = wb_ctrl_q;
    assign wb_dst      = wb_dst_q;
    assign Stall       = stall_c;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: an instruction-level pipeline model predicts
// each cycle's outputs, a separate monitor pops and compares them at the falling edge.
`timescale 1ns/1ps

module tb_ctrl_pipe_hazard;

    localparam int CNT_W = 4;

    typedef struct {
        logic [8:0] exc;
        logic [5:0] memc;
        logic [9:0] wbc;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    typedef struct {
        logic [8:0]       ex_ctrl;
        logic [4:0]       ex_rs;
        logic [4:0]       ex_rt;
        logic [4:0]       ex_dst;
        logic [5:0]       mem_ctrl;
        logic [4:0]       mem_dst;
        logic [9:0]       wb_ctrl;
        logic [4:0]       wb_dst;
        logic             stall;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [8:0]       id_ex_ctrl = '0;
    logic [5:0]       id_mem_ctrl = '0;
    logic [9:0]       id_wb_ctrl = '0;
    logic [4:0]       id_rs = '0, id_rt = '0, id_rd = '0;
    logic             id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_is_branch = 1'b0, flush = 1'b0;
    logic [8:0]       ex_ctrl;
    logic [4:0]       ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic [5:0]       mem_ctrl;
    logic [9:0]       wb_ctrl;
    logic             Stall;
    logic [CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t   sb[$];
    instr_t m_ex, m_mem, m_wb;
    int     m_cnt;
    instr_t nop;

    ctrl_pipe_hazard #(.CNT_W(CNT_W), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_ctrl(id_ex_ctrl), .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .flush(flush),
        .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .mem_ctrl(mem_ctrl), .mem_dst(mem_dst), .wb_ctrl(wb_ctrl), .wb_dst(wb_dst),
        .Stall(Stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic instr_t mk(input logic [8:0] exc, input logic [5:0] memc, input logic [9:0] wbc,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        instr_t i;
        i.exc = exc; i.memc = memc; i.wbc = wbc; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    // Register an instruction writes back: RegDst chooses rt, rd, the link register or none
    function automatic logic [4:0] dstOf(input instr_t i);
        case (i.exc[3:2])
            2'd0:    return i.rt;
            2'd1:    return i.rd;
            2'd2:    return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic bit consumes(input logic [4:0] r, input instr_t id, input bit urs, input bit urt);
        return (r != 0) && ((urs && r == id.rs) || (urt && r == id.rt));
    endfunction

    function automatic bit isLoad(input instr_t i);
        return i.memc[0] && i.wbc[0];
    endfunction

    // One cycle: predict what the DUT shows with these ID inputs, then advance the model
    task automatic applyStimulus(input instr_t id, input bit urs, input bit urt, input bit br,
                                 input bit fl, output bit stall);
        exp_t e;
        @(posedge clk);
        #1;
        id_ex_ctrl = id.exc; id_mem_ctrl = id.memc; id_wb_ctrl = id.wbc;
        id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
        id_uses_rs = urs; id_uses_rt = urt; id_is_branch = br; flush = fl;

        stall = (isLoad(m_ex) && consumes(dstOf(m_ex), id, urs, urt)) ||
                (br && m_ex.wbc[0] && consumes(dstOf(m_ex), id, urs, urt)) ||
                (br && isLoad(m_mem) && consumes(dstOf(m_mem), id, urs, urt));

        e.ex_ctrl = m_ex.exc;  e.ex_rs = m_ex.rs; e.ex_rt = m_ex.rt; e.ex_dst = dstOf(m_ex);
        e.mem_ctrl = m_mem.memc; e.mem_dst = dstOf(m_mem);
        e.wb_ctrl = m_wb.wbc; e.wb_dst = dstOf(m_wb);
        e.stall = stall; e.cnt = CNT_W'(m_cnt);
        sb.push_back(e);

        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (stall || fl) ? nop : id;
        if (stall && m_cnt < (2**CNT_W - 1)) m_cnt++;
    endtask

    // Controller behaviour: an instruction is re-presented in ID for as long as it stalls
    task automatic issueInstr(input instr_t id, input bit urs, input bit urt, input bit br, input bit fl);
        bit st;
        int k = 0;
        do begin
            applyStimulus(id, urs, urt, br, fl, st);
            k++;
        end while (st && k < 4);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ex_ctrl"}, 32'(ex_ctrl), 0);
        checkOutput({tag, " ex_rs"}, 32'(ex_rs), 0);
        checkOutput({tag, " ex_rt"}, 32'(ex_rt), 0);
        checkOutput({tag, " ex_dst"}, 32'(ex_dst), 0);
        checkOutput({tag, " mem_ctrl"}, 32'(mem_ctrl), 0);
        checkOutput({tag, " mem_dst"}, 32'(mem_dst), 0);
        checkOutput({tag, " wb_ctrl"}, 32'(wb_ctrl), 0);
        checkOutput({tag, " wb_dst"}, 32'(wb_dst), 0);
        checkOutput({tag, " Stall"}, 32'(Stall), 0);
        checkOutput({tag, " stall_count"}, 32'(stall_count), 0);
    endtask

    // Asserted just after a falling edge so it lands mid-cycle, away from both clock edges
    task automatic doReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkAllZero("reset_async");
        id_ex_ctrl = '0; id_mem_ctrl = '0; id_wb_ctrl = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0; flush = 0;
        @(posedge clk);
        #2 checkAllZero("reset_held");
        @(negedge clk);
        #2 rst_n = 1'b1;
        m_ex = nop; m_mem = nop; m_wb = nop; m_cnt = 0;
    endtask

    function automatic instr_t randInstr();
        return mk(9'($urandom), 6'($urandom), 10'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("ex_ctrl", 32'(ex_ctrl), 32'(e.ex_ctrl));
                checkOutput("ex_rs", 32'(ex_rs), 32'(e.ex_rs));
                checkOutput("ex_rt", 32'(ex_rt), 32'(e.ex_rt));
                checkOutput("ex_dst", 32'(ex_dst), 32'(e.ex_dst));
                checkOutput("mem_ctrl", 32'(mem_ctrl), 32'(e.mem_ctrl));
                checkOutput("mem_dst", 32'(mem_dst), 32'(e.mem_dst));
                checkOutput("wb_ctrl", 32'(wb_ctrl), 32'(e.wb_ctrl));
                checkOutput("wb_dst", 32'(wb_dst), 32'(e.wb_dst));
                checkOutput("Stall", 32'(Stall), 32'(e.stall));
                checkOutput("stall_count", 32'(stall_count), 32'(e.cnt));
            end
        end
    end

    initial begin : driver
        instr_t addi9, jal, lw8, add8, lw0, add0, add5, beq5, lw5, beqrt5, sw, lw7, beq7;
        bit st;
        nop = mk('0, '0, '0, '0, '0, '0);
        m_ex = nop; m_mem = nop; m_wb = nop; m_cnt = 0;

        addi9  = mk(9'h001, 6'h00, 10'h001, 5'd0, 5'd9, 5'd0);
        jal    = mk(9'h008, 6'h00, 10'h001, 5'd0, 5'd0, 5'd0);
        lw8    = mk(9'h001, 6'h01, 10'h003, 5'd0, 5'd8, 5'd0);
        add8   = mk(9'h024, 6'h00, 10'h001, 5'd8, 5'd0, 5'd10);
        lw0    = mk(9'h001, 6'h01, 10'h003, 5'd0, 5'd0, 5'd0);
        add0   = mk(9'h024, 6'h00, 10'h001, 5'd0, 5'd0, 5'd10);
        add5   = mk(9'h024, 6'h00, 10'h001, 5'd1, 5'd2, 5'd5);
        beq5   = mk(9'h010, 6'h00, 10'h000, 5'd5, 5'd0, 5'd0);
        lw5    = mk(9'h001, 6'h01, 10'h003, 5'd0, 5'd5, 5'd0);
        beqrt5 = mk(9'h010, 6'h00, 10'h000, 5'd3, 5'd5, 5'd0);
        sw     = mk(9'h001, 6'h0e, 10'h000, 5'd2, 5'd4, 5'd0);
        lw7    = mk(9'h001, 6'h01, 10'h003, 5'd0, 5'd7, 5'd0);
        beq7   = mk(9'h010, 6'h00, 10'h000, 5'd7, 5'd0, 5'd0);

        #3 checkAllZero("power_on");
        @(negedge clk);
        #2 rst_n = 1'b1;

        issueInstr(addi9, 1, 0, 0, 0);
        issueInstr(jal, 0, 0, 0, 0);
        repeat (3) issueInstr(nop, 0, 0, 0, 0);

        issueInstr(lw8, 1, 0, 0, 0);
        issueInstr(add8, 1, 1, 0, 0);
        issueInstr(lw0, 1, 0, 0, 0);
        issueInstr(add0, 1, 1, 0, 0);
        repeat (2) issueInstr(nop, 0, 0, 0, 0);

        issueInstr(add5, 1, 1, 0, 0);
        issueInstr(beq5, 1, 1, 1, 0);
        issueInstr(lw5, 1, 0, 0, 0);
        issueInstr(beqrt5, 1, 1, 1, 0);
        repeat (2) issueInstr(nop, 0, 0, 0, 0);

        issueInstr(sw, 1, 1, 0, 1);
        repeat (3) issueInstr(nop, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            issueInstr(lw5, 1, 0, 0, 0);
            issueInstr(beq5, 1, 1, 1, 0);
        end
        repeat (3) issueInstr(nop, 0, 0, 0, 0);

        issueInstr(lw7, 1, 0, 0, 0);
        applyStimulus(beq7, 1, 1, 1, 0, st);
        doReset();

        for (int i = 0; i < 400; i++) begin
            applyStimulus(randInstr(), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), st);
        end
        doReset();
        for (int i = 0; i < 60; i++) begin
            applyStimulus(randInstr(), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), st);
        end

        repeat (2) @(negedge clk);
        #1 checkOutput("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Sits directly downstream of the ID-stage instruction decoder/controller.
- Captures the decoder's EX/MEM/WB control groups plus register specifiers into the ID/EX, EX/MEM and MEM/WB control pipeline registers.
- Resolves the EX-stage destination register from RegDst.
- Detects load-use and ID-branch data hazards and generates the Stall fed back to the controller, PC and IF/ID, inserting a bubble into ID/EX.

Parameters:
- CNT_W, 16, width of saturating stall-cycle counter
- LINK_REG, 31, destination register number used when RegDst==2 (jal)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_ex_ctrl  in  9  {small_big_32_MUX, ALUOp[3:0], RegDst[1:0], Shift, ALUSrc} from decoder
- id_mem_ctrl  in  6  {small_big_16_MUX, readSAD, StoreMux[1:0], MemWrite, MemRead}
- id_wb_ctrl  in  10  {write_min, read_min, small_big_find, SAD_RegFile_write, small_big_regFile, LoadMux[1:0], MemToReg[1:0], RegWrite}
- id_rs, id_rt, id_rd  in  5 each  register fields of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs/rt
- id_is_branch  in  1  ID instruction is beq/bne/bgez/bltz/bgtz/blez/jr (compares in ID)
- flush  in  1  squash ID instruction (insert bubble into ID/EX, no stall)
- ex_ctrl  out  9  ID/EX copy of id_ex_ctrl
- ex_rs, ex_rt  out  5 each  ID/EX register specifiers
- ex_dst  out  5  combinational: RegDst 0→ex_rt, 1→ex_rd, 2→LINK_REG, 3→0
- mem_ctrl  out  6  EX/MEM memory control group
- mem_dst  out  5  EX/MEM destination register
- wb_ctrl  out  10  MEM/WB write-back control group
- wb_dst  out  5  MEM/WB destination register
- Stall  out  1  combinational hazard stall to controller, PC, IF/ID
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0): all pipeline registers, ex_ctrl, mem_ctrl, wb_ctrl, ex_rs/rt/rd, mem_dst, wb_dst, stall_count = 0. Stall is then 0, since all RegWrite/MemRead bits are 0.
- Pipeline: 1 cycle per stage. ID/EX ← ID inputs; EX/MEM ← {ex MEM group, ex WB group, ex_dst}; MEM/WB ← {mem WB group, mem_dst}. ID→WB control latency is exactly 3 edges.
- Bubble: when Stall=1 or flush=1, ID/EX loads all-zero control and zero specifiers. EX/MEM and MEM/WB always advance; only ID and earlier freeze.
- Hazard definitions (dst != 0 required in all; match = (dst==id_rs & id_uses_rs) | (dst==id_rt & id_uses_rt)):
  - H1 load-use: ex MemRead & ex RegWrite & match(ex_dst)
  - H2 branch-after-ALU: id_is_branch & ex RegWrite & match(ex_dst)
  - H3 branch-after-load: id_is_branch & mem MemRead & mem RegWrite & match(mem_dst)
- Stall = H1|H2|H3, combinational from current register state and ID inputs; no registered state machine.
- Resulting stall lengths: load then dependent ALU op = 1 cycle; ALU op then dependent branch = 1 cycle; load then dependent branch = 2 cycles (H1 then H3).
- flush and Stall both 1: bubble inserted, Stall still asserted.
- stall_count increments on each edge with Stall=1 and saturates at all-ones.
- Register 0 is never a hazard source; SAD/min competition bits are pure passthrough with no hazard effect.
- Reset mid-stall: bubble state cleared immediately; Stall deasserts combinationally.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with nonzero pipeline → all outputs 0 before next edge; Stall=0.
- Passthrough: addi ($t1=9, RegWrite=1, ALUSrc=1) then NOPs → ex_ctrl after 1 edge, mem_ctrl after 2, wb_ctrl RegWrite=1 and wb_dst=9 after 3; RegDst=2 gives ex_dst=31.
- Load-use: lw rt=8, then add rs=8 → Stall=1 for exactly 1 cycle, ID/EX all-zero bubble, stall_count=1; with rt=0 → no stall.
- Branch: add rd=5 then beq rs=5 → 1-cycle stall. lw rt=5 then beq rt=5 → 2 consecutive stall cycles, stall_count=2.
- Flush: flush=1 with valid sw in ID → ex_ctrl=0, mem_ctrl MemWrite never asserted, Stall=0.
- Saturation: with CNT_W=4, hold a hazard for 20 cycles → stall_count stops at 15.
